// File: rtl/ins_fetch_pkg.sv
// Shared constants for the instruction fetch unit: opcode values, FSM encoding
// and the queue entry layout. JAL predecode is enabled by INS_FETCH_JAL_REDIRECT_EN.
package ins_fetch_pkg;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } fetch_entry_t;

    // J-type immediate: imm[20|10:1|11|19:12] scattered over inst[31:12]
    function automatic logic [31:0] j_imm(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Fetch-unit bus: instruction-cache request/response, decode-side queue head
// and the commit-side flush redirect.
interface ins_fetch_if;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pred_jump;
    logic        decode_ready;
    logic        flush_in;
    logic [31:0] flush_pc;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_resp_valid, icache_resp_inst,
        output inst_valid, inst, inst_pc, inst_pred_jump,
        input  decode_ready, flush_in, flush_pc
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_resp_valid, icache_resp_inst,
        input  inst_valid, inst, inst_pc, inst_pred_jump,
        output decode_ready, flush_in, flush_pc
    );
endinterface

// File: rtl/ins_fetch_queue.sv
// Instruction queue: power-of-two circular FIFO with push, pop, flush and an
// occupancy count. Storage is cleared on reset so the head reads as zero.
module ins_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: one outstanding icache request, results buffered in
// ins_queue. Define INS_FETCH_JAL_REDIRECT_EN to redirect fetch on predecoded JAL.
//
//   state      | meaning
//   ST_IDLE    | may issue a request at pc when the queue has room
//   ST_WAIT    | request outstanding, held stable until the response
//   ST_DISCARD | flushed while waiting; next response is dropped
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    ins_fetch_if.master bus
);
    localparam int CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_next;
    logic          pred;
    logic [CW-1:0] count;
    logic          q_empty, can_issue, resp_take, flush_take, pop, req_valid;
    fetch_entry_t  push_entry, head_entry;

    assign can_issue  = count < CW'(IQ_DEPTH);
    assign flush_take = rdy_in && bus.flush_in;
    assign resp_take  = rdy_in && !bus.flush_in && (state_q == ST_WAIT) && bus.icache_resp_valid;

`ifdef INS_FETCH_JAL_REDIRECT_EN
    always_comb begin
        pred    = (bus.icache_resp_inst[6:0] == OPC_JAL);
        pc_next = pred ? pc_q + j_imm(bus.icache_resp_inst) : pc_q + INST_BYTES;
    end
`else
    always_comb begin
        pred    = 1'b0;
        pc_next = pc_q + INST_BYTES;
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (bus.flush_in) begin
                // a request still in flight must have its response swallowed
                if (state_q != ST_IDLE && !bus.icache_resp_valid) state_d = ST_DISCARD;
                else                                              state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:             if (can_issue) state_d = ST_WAIT;
                    ST_WAIT, ST_DISCARD: if (bus.icache_resp_valid) state_d = ST_IDLE;
                    default:             state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        req_valid = 1'b0;
        if (!rst_in && !bus.flush_in) begin
            case (state_q)
                ST_IDLE: req_valid = rdy_in && can_issue;
                ST_WAIT: req_valid = 1'b1;
                default: req_valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)          pc_q <= RESET_PC;
        else if (flush_take) pc_q <= bus.flush_pc;
        else if (resp_take)  pc_q <= pc_next;
    end

    assign push_entry = '{inst: bus.icache_resp_inst, pc: pc_q, pred: pred};
    assign pop        = bus.inst_valid && bus.decode_ready;

    ins_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (resp_take),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush_take),
        .head_data (head_entry),
        .count     (count),
        .empty     (q_empty)
    );

    assign bus.icache_req_valid = req_valid;
    assign bus.icache_req_addr  = req_valid ? pc_q : 32'h0;
    assign bus.inst_valid       = !q_empty && rdy_in;
    assign bus.inst             = head_entry.inst;
    assign bus.inst_pc          = head_entry.pc;
    assign bus.inst_pred_jump   = head_entry.pred;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: responses are modelled by the bench, expected
// queue entries go into a scoreboard and are checked as decode pops them.
module tb_ins_fetch;
    import ins_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    ins_fetch_if bus();

    ins_fetch #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL_W = 32'h0080_006F;
`ifdef INS_FETCH_JAL_REDIRECT_EN
    localparam logic [31:0] JAL_NEXT = 32'd8;
    localparam logic        JAL_PRED = 1'b1;
`else
    localparam logic [31:0] JAL_NEXT = 32'd4;
    localparam logic        JAL_PRED = 1'b0;
`endif

    int           n_cmp = 0;
    int           n_err = 0;
    fetch_entry_t sb[$];
    logic [31:0]  mpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // advance one cycle; a pop taken at this edge is checked against the scoreboard
    task automatic tick();
        fetch_entry_t e;
        if (bus.inst_valid && bus.decode_ready && !bus.flush_in) begin
            chk1("pop_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_inst", bus.inst, e.inst);
                chk("pop_pc", bus.inst_pc, e.pc);
                chk1("pop_pred", bus.inst_pred_jump, e.pred);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.icache_req_valid && n < 30) begin
            tick();
            n++;
        end
        chk1({tag, "_req_seen"}, bus.icache_req_valid, 1'b1);
    endtask

    task automatic serve(input string tag, input logic [31:0] word, input logic p,
                         input logic [31:0] nxt);
        wait_req(tag);
        chk({tag, "_addr"}, bus.icache_req_addr, mpc);
        tick();
        chk({tag, "_addr_hold"}, bus.icache_req_addr, mpc);
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_inst  = word;
        sb.push_back('{inst: word, pc: mpc, pred: p});
        tick();
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_inst  = '0;
        mpc = nxt;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.decode_ready = 1'b1;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
        chk1({tag, "_empty_after"}, bus.inst_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_inst  = '0;
        bus.decode_ready      = 1'b0;
        bus.flush_in          = 1'b0;
        bus.flush_pc          = '0;
        mpc = 32'h0;

        // reset state
        @(posedge clk);
        #1;
        chk1("rst_req_valid", bus.icache_req_valid, 1'b0);
        chk("rst_req_addr", bus.icache_req_addr, 32'h0);
        chk1("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk1("rst_pred", bus.inst_pred_jump, 1'b0);
        rst = 1'b0;
        #1;
        chk1("post_rst_req", bus.icache_req_valid, 1'b1);

        // sequential fetch with decode always ready
        bus.decode_ready = 1'b1;
        serve("seq0", NOP, 1'b0, 32'd4);
        serve("seq1", NOP, 1'b0, 32'd8);
        serve("seq2", NOP, 1'b0, 32'd12);
        drain("seq");

        // queue fills to depth with decode stalled
        bus.decode_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            serve("fill", NOP | (32'(i + 1) << 7), 1'b0, mpc + 32'd4);
        repeat (5) begin
            tick();
            chk1("full_no_req", bus.icache_req_valid, 1'b0);
            chk1("full_inst_valid", bus.inst_valid, 1'b1);
        end
        bus.decode_ready = 1'b1;
        tick();
        bus.decode_ready = 1'b0;
        chk1("req_after_pop", bus.icache_req_valid, 1'b1);
        chk("req_after_pop_addr", bus.icache_req_addr, mpc);
        drain("fill");

        // rdy_in low while a request is outstanding
        bus.decode_ready = 1'b0;
        serve("rdy0", 32'h0010_0093, 1'b0, mpc + 32'd4);
        wait_req("rdy_w");
        tick();
        rdy = 1'b0;
        repeat (3) begin
            tick();
            chk1("frz_req", bus.icache_req_valid, 1'b1);
            chk("frz_addr", bus.icache_req_addr, mpc);
            chk1("frz_inst_valid", bus.inst_valid, 1'b0);
        end
        rdy = 1'b1;
        #1;
        chk1("unfrz_inst_valid", bus.inst_valid, 1'b1);
        serve("rdy1", 32'h0020_0113, 1'b0, mpc + 32'd4);
        drain("rdy");

        // flush while waiting: late response dropped
        bus.decode_ready = 1'b0;
        serve("fw_pre", NOP, 1'b0, mpc + 32'd4);
        wait_req("fw_w");
        tick();
        bus.flush_in = 1'b1;
        bus.flush_pc = 32'h100;
        #1;
        chk1("fw_no_req_in_flush", bus.icache_req_valid, 1'b0);
        tick();
        bus.flush_in = 1'b0;
        sb.delete();
        mpc = 32'h100;
        chk1("fw_inst_valid", bus.inst_valid, 1'b0);
        chk1("fw_discard_no_req", bus.icache_req_valid, 1'b0);
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_inst  = 32'hDEAD_0013;
        tick();
        bus.icache_resp_valid = 1'b0;
        chk1("fw_late_dropped", bus.inst_valid, 1'b0);
        bus.decode_ready = 1'b1;
        serve("fw_tgt", NOP, 1'b0, 32'h104);
        drain("fw");

        // flush coincident with a response
        bus.decode_ready = 1'b0;
        serve("fr_pre", NOP, 1'b0, mpc + 32'd4);
        wait_req("fr_w");
        tick();
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_inst  = 32'hBEEF_0013;
        bus.flush_in = 1'b1;
        bus.flush_pc = 32'h200;
        tick();
        bus.icache_resp_valid = 1'b0;
        bus.flush_in = 1'b0;
        sb.delete();
        mpc = 32'h200;
        chk1("fr_no_push", bus.inst_valid, 1'b0);
        serve("fr_tgt", NOP, 1'b0, 32'h204);
        drain("fr");

        // reset mid-request, stray response in IDLE, then JAL at pc 0
        bus.decode_ready = 1'b0;
        serve("mr_pre", NOP, 1'b0, mpc + 32'd4);
        wait_req("mr_w");
        tick();
        rst = 1'b1;
        #1;
        chk1("mr_req_valid", bus.icache_req_valid, 1'b0);
        chk1("mr_inst_valid", bus.inst_valid, 1'b0);
        tick();
        rst = 1'b0;
        sb.delete();
        mpc = 32'h0;
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_inst  = 32'h0100_006F;
        tick();
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_inst  = '0;
        chk1("idle_resp_ignored", bus.inst_valid, 1'b0);
        serve("jal", JAL_W, JAL_PRED, JAL_NEXT);
        bus.decode_ready = 1'b1;
        serve("jal_tgt", NOP, 1'b0, mpc + 32'd4);
        drain("jal");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
